ram_access_ctrl: RTL and testbench

- Initiator side of the 512x16 single-port RAM interface (clk, WE, ad[8:0], in[15:0], out[15:0]).
- Accepts host commands over a valid/ready handshake and drives the RAM to do single writes, single reads, incrementing block fills and block checksums.
- Sits between a CPU/host datapath and the RAM.
- Sole driver of the RAM's WE, ad and in.

---
 rtl/ram_access_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator for a single-port RAM (ram_we=0 writes, ram_we=1 reads).
// Handles host WRITE / READ / FILL / SUM commands over a valid/ready handshake.
// Optional feature macro: RAM_ACCESS_STREAM_EN (per-word SUM read stream on strm_*).
module ram_access_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 9,
  parameter int unsigned DW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          done,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out,
  output logic          strm_valid,
  output logic [DW-1:0] strm_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_FILL,
    S_SUM_RUN,
    S_SUM_DRAIN,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_SUM   = 2'b11
  } op_e;

  localparam logic [1:0]  LAT     = 2'(RD_LAT);
  localparam logic [AW:0] REM_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   rem_q, rem_d;
  logic [1:0]    lat_q, lat_d;
  logic [RD_LAT-1:0] sr_q, sr_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] sum_next;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_ad_q, ram_ad_d;
  logic [DW-1:0] ram_in_q, ram_in_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          done_q, done_d;
  logic          word_tagged;

  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = !rst && (state_q == S_IDLE);
  assign word_tagged = sr_q[RD_LAT-1];
  assign sum_next    = acc_q + (word_tagged ? ram_out : '0);

  // RAM bus signals are registered; ram_ad_q/ram_in_q double as the FILL/SUM
  // address and data iterators, so each state sets up the next cycle's bus.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    lat_d       = lat_q;
    sr_d        = sr_q << 1;
    sr_d[0]     = (state_q == S_SUM_RUN);
    acc_d       = acc_q;
    ram_we_d    = 1'b1;
    ram_ad_d    = ram_ad_q;
    ram_in_d    = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rem_d    = {(cmd_len == '0), cmd_len};
          lat_d    = '0;
          acc_d    = '0;
          ram_ad_d = cmd_addr;
          case (op_e'(cmd_op))
            OP_WRITE: begin
              state_d  = S_WRITE;
              ram_we_d = 1'b0;
              ram_in_d = cmd_data;
            end
            OP_READ:  state_d = S_READ_WAIT;
            OP_FILL: begin
              state_d  = S_FILL;
              ram_we_d = 1'b0;
              ram_in_d = cmd_data;
            end
            default:  state_d = S_SUM_RUN;
          endcase
        end
      end

      S_WRITE: begin
        state_d = S_FINISH;
        done_d  = 1'b1;
      end

      S_READ_WAIT: begin
        if (lat_q == LAT) begin
          state_d     = S_FINISH;
          done_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ram_out;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_FILL: begin
        if (rem_q == REM_ONE) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          rem_d    = rem_q - 1'b1;
          ram_we_d = 1'b0;
          ram_ad_d = ram_ad_q + 1'b1;
          ram_in_d = ram_in_q + 1'b1;
        end
      end

      S_SUM_RUN: begin
        acc_d = sum_next;
        if (rem_q == REM_ONE) begin
          state_d = S_SUM_DRAIN;
          lat_d   = 2'd1;
        end else begin
          rem_d    = rem_q - 1'b1;
          ram_ad_d = ram_ad_q + 1'b1;
        end
      end

      S_SUM_DRAIN: begin
        acc_d = sum_next;
        if (lat_q == LAT) begin
          state_d     = S_FINISH;
          done_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sum_next;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      lat_q       <= '0;
      sr_q        <= '0;
      acc_q       <= '0;
      ram_we_q    <= 1'b1;
      ram_ad_q    <= '0;
      ram_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      ram_we_q    <= ram_we_d;
      ram_ad_q    <= ram_ad_d;
      ram_in_q    <= ram_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_ad    = ram_ad_q;
  assign ram_in    = ram_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;

`ifdef RAM_ACCESS_STREAM_EN
  logic          strm_valid_q, strm_valid_d;
  logic [DW-1:0] strm_data_q, strm_data_d;

  always_comb begin
    strm_valid_d = word_tagged;
    strm_data_d  = word_tagged ? ram_out : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strm_valid_q <= 1'b0;
      strm_data_q  <= '0;
    end else begin
      strm_valid_q <= strm_valid_d;
      strm_data_q  <= strm_data_d;
    end
  end

  assign strm_valid = strm_valid_q;
  assign strm_data  = strm_data_q;
`else
  assign strm_valid = 1'b0;
  assign strm_data  = '0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural RAM and memory model.
module tb_ram_access_ctrl;

  localparam int unsigned TB_LAT = 2;
  localparam int unsigned AW     = 9;
  localparam int unsigned DW     = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        done;
  logic        busy;
  logic        ram_we;
  logic [8:0]  ram_ad;
  logic [15:0] ram_in;
  logic [15:0] ram_out;
  logic        strm_valid;
  logic [15:0] strm_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_ram [512];
  logic [15:0] rd_pipe [TB_LAT];
  logic [15:0] ref_mem [512];

  typedef struct {
    logic [1:0]  op;
    int unsigned addr;
    int unsigned len;
    logic [15:0] data;
    logic        chk_rsp;
    logic [15:0] exp_rsp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  ram_access_ctrl #(.RD_LAT(TB_LAT), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .done       (done),
    .busy       (busy),
    .ram_we     (ram_we),
    .ram_ad     (ram_ad),
    .ram_in     (ram_in),
    .ram_out    (ram_out),
    .strm_valid (strm_valid),
    .strm_data  (strm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 512x16 single-port RAM: write when ram_we=0, read data after TB_LAT cycles.
  always @(posedge clk) begin
    if (!ram_we) mem_ram[ram_ad] <= ram_in;
    rd_pipe[0] <= mem_ram[ram_ad];
    for (int i = 1; i < TB_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_out = rd_pipe[TB_LAT-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic mem_compare(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem_ram[i] !== ref_mem[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Runs one command through the handshake; expectations come from ref_mem.
  task automatic run_cmd(input logic [1:0] op, input int unsigned addr, input int unsigned len,
                         input logic [15:0] data, output logic [15:0] got_rsp, output int got_lat);
    int unsigned n;
    int          exp_lat;
    logic        exp_has_rsp;
    logic [15:0] exp_rsp;
    logic [15:0] exp_words [$];
    logic [15:0] strm_words [$];
    int          strm_first;
    int          strm_last;
    int          rsp_cnt;
    int          rsp_lat;
    int          busy_errs;
    int          cyc;
    int          bad;
    logic [8:0]  a9;

    n = (len == 0) ? 512 : len;
    case (op)
      2'b00:   exp_lat = 1;
      2'b01:   exp_lat = TB_LAT + 1;
      2'b10:   exp_lat = n;
      default: exp_lat = n + TB_LAT;
    endcase
    exp_has_rsp = (op == 2'b01) || (op == 2'b11);
    exp_rsp = '0;
    if (op == 2'b01) exp_rsp = ref_mem[9'(addr)];
    if (op == 2'b11) begin
      for (int unsigned i = 0; i < n; i++) begin
        a9 = 9'(addr + i);
        exp_rsp = exp_rsp + ref_mem[a9];
        exp_words.push_back(ref_mem[a9]);
      end
    end

    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = 9'(addr);
    cmd_len   = 9'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 9'($urandom);
    cmd_len   = 9'($urandom);
    cmd_data  = 16'($urandom);

    got_rsp = '0; got_lat = -1; rsp_cnt = 0; rsp_lat = -1; busy_errs = 0;
    strm_first = -1; strm_last = -1; cyc = 1;
    while (got_lat < 0 && cyc <= exp_lat + 20) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_errs++;
      if (strm_valid === 1'b1) begin
        strm_words.push_back(strm_data);
        if (strm_first < 0) strm_first = cyc;
        strm_last = cyc;
      end
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        got_rsp = rsp_data;
        rsp_lat = cyc - 1;
      end
      if (done === 1'b1) got_lat = cyc - 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end

    @(negedge clk);
    if (strm_valid === 1'b1) begin
      strm_words.push_back(strm_data);
      strm_last = cyc + 1;
    end
    chk("done_latency", got_lat, exp_lat);
    chk("rsp_count", rsp_cnt, {31'd0, exp_has_rsp});
    if (exp_has_rsp) begin
      chk("rsp_latency", rsp_lat, exp_lat);
      chk("rsp_data", {16'd0, got_rsp}, {16'd0, exp_rsp});
    end
    chk("busy_span", busy_errs, 0);
    chk("done_one_cycle", {done, rsp_valid, busy, cmd_ready}, 4'b0001);
    chk("idle_bus", {ram_we, ram_in}, {1'b1, 16'h0000});

`ifdef RAM_ACCESS_STREAM_EN
    if (op == 2'b11) begin
      chk("strm_count", strm_words.size(), n);
      bad = 0;
      for (int i = 0; i < strm_words.size() && i < exp_words.size(); i++)
        if (strm_words[i] !== exp_words[i]) bad++;
      chk("strm_data", bad, 0);
      chk("strm_contiguous", strm_last - strm_first, n - 1);
    end else begin
      chk("strm_count_nonsum", strm_words.size(), 0);
    end
`else
    bad = strm_words.size();
    if (strm_data !== 16'h0000) bad++;
    chk("strm_tied_off", bad, 0);
`endif

    if (op == 2'b00) ref_mem[9'(addr)] = data;
    if (op == 2'b10)
      for (int unsigned i = 0; i < n; i++) ref_mem[9'(addr + i)] = data + 16'(i);
  endtask

  initial begin
    logic [15:0] got_rsp;
    logic [15:0] v;
    int          got_lat;
    int          cyc;
    int          errs;
    logic [15:0] old300;

    vecs[0]  = '{2'b00,   0,  0, 16'h000F, 1'b0, 16'h0000, 1};
    vecs[1]  = '{2'b00,   1,  0, 16'h00F0, 1'b0, 16'h0000, 1};
    vecs[2]  = '{2'b01,   0,  0, 16'h0000, 1'b1, 16'h000F, TB_LAT + 1};
    vecs[3]  = '{2'b01,   1,  0, 16'h0000, 1'b1, 16'h00F0, TB_LAT + 1};
    vecs[4]  = '{2'b10, 510,  4, 16'h1000, 1'b0, 16'h0000, 4};
    vecs[5]  = '{2'b11, 510,  4, 16'h0000, 1'b1, 16'h4006, 4 + TB_LAT};
    vecs[6]  = '{2'b01, 511,  0, 16'h0000, 1'b1, 16'h1001, TB_LAT + 1};
    vecs[7]  = '{2'b10,   0,  0, 16'hFFFF, 1'b0, 16'h0000, 512};
    vecs[8]  = '{2'b11,   0,  0, 16'h0000, 1'b1, 16'hFD00, 512 + TB_LAT};
    vecs[9]  = '{2'b01,   0,  0, 16'h0000, 1'b1, 16'hFFFF, TB_LAT + 1};
    vecs[10] = '{2'b01,   1,  0, 16'h0000, 1'b1, 16'h0000, TB_LAT + 1};
    vecs[11] = '{2'b01, 511,  0, 16'h0000, 1'b1, 16'h01FE, TB_LAT + 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
    for (int i = 0; i < 512; i++) begin
      v = 16'($urandom);
      mem_ram[i] = v;
      ref_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    chk("reset_ready_low", cmd_ready, 0);
    chk("reset_ctrl", {busy, done, rsp_valid, ram_we}, 4'b0001);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_bus", {ram_ad, ram_in}, 0);
    chk("reset_strm", {strm_valid, strm_data}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data, got_rsp, got_lat);
      chk($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
      if (vecs[i].chk_rsp) chk($sformatf("vec%0d_rsp", i), {16'd0, got_rsp}, {16'd0, vecs[i].exp_rsp});
    end
    mem_compare("mem_after_table");

    // WRITE held on cmd_valid throughout a FILL must wait until the FILL is done.
    old300 = ref_mem[300];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 9'd100; cmd_len = 9'd8; cmd_data = 16'h2000;
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 9'd300; cmd_len = 9'($urandom); cmd_data = 16'hBEEF;
    cyc = 1; got_lat = -1; errs = 0;
    while (got_lat < 0 && cyc < 40) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1) errs++;
      if (done === 1'b1) got_lat = cyc - 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("hold_fill_latency", got_lat, 8);
    chk("hold_ready_low", errs, 0);
    chk("hold_no_early_write", {16'd0, mem_ram[300]}, {16'd0, old300});
    @(negedge clk);
    chk("hold_ready_after_done", {cmd_ready, busy}, 2'b10);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_write_accepted", busy, 1);
    @(negedge clk);
    chk("hold_write_done", done, 1);
    @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) ref_mem[9'(100 + i)] = 16'h2000 + 16'(i);
    ref_mem[300] = 16'hBEEF;
    mem_compare("mem_after_hold");

    // Reset lands on the edge that would perform the third FILL write.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 9'd200; cmd_len = 9'd8; cmd_data = 16'h3000;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fill_word0_bus", {ram_we, ram_ad, ram_in}, {1'b0, 9'd200, 16'h3000});
    @(negedge clk);
    chk("fill_word1_bus", {ram_we, ram_ad, ram_in}, {1'b0, 9'd201, 16'h3001});
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_low", cmd_ready, 0);
    chk("abort_ctrl", {busy, done, rsp_valid, ram_we}, 4'b0001);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_bus", {ram_ad, ram_in}, 0);
    chk("abort_strm", {strm_valid, strm_data}, 0);
    rst = 1'b0;
    errs = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || rsp_valid !== 1'b0 || ram_we !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("abort_quiet", errs, 0);
    ref_mem[200] = 16'h3000;
    ref_mem[201] = 16'h3001;
    mem_compare("mem_after_abort");

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  rop;
      int unsigned raddr;
      int unsigned rlen;
      rop   = 2'($urandom_range(0, 3));
      raddr = $urandom_range(0, 511);
      rlen  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 24);
      run_cmd(rop, raddr, rlen, 16'($urandom), got_rsp, got_lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    mem_compare("mem_after_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
